alu_iter_exec: RTL and testbench
================================

Name: alu_iter_exec

Overview:
- Sequential execute unit that consumes the 3-bit ALU_Control code produced by the ALU decoder, together with two operands, and returns a result.
- Logic/arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle, to save area.
- Sits between the decode/register-read stage and writeback. Uses a valid/ready handshake on both sides so the pipeline can stall during long shifts.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; shift amount is B[SHAMT_W-1:0]; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operation request valid.
- IN_READY  output  1  unit can accept a request.
- ALU_Control  input  3  operation code from the ALU decoder.
- A  input  WIDTH  operand A (value shifted for shifts).
- B  input  WIDTH  operand B (low SHAMT_W bits = shift amount for shifts).
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts result.
- RESULT  output  WIDTH  operation result.
- ZERO  output  1  RESULT == 0; meaningful only while OUT_VALID=1.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset values: IN_READY=1, OUT_VALID=0, RESULT=0, ZERO=1, state=IDLE, shift counter=0.
- ALU_Control encoding (team-fixed):
  - 000 ADD, 001 SUB, 010 AND, 011 OR.
  - 100 XOR, 101 SLT (signed; RESULT = {WIDTH-1 zeros, A<B}).
  - 110 SLL, 111 SRL (logical).
- Arithmetic: ADD/SUB wrap modulo 2**WIDTH; no carry or overflow outputs.
- State machine IDLE / SHIFT / DONE:
  - IDLE: IN_READY=1, OUT_VALID=0. On IN_VALID=1, capture ALU_Control, A, B.
    - Non-shift op: RESULT computed and registered; go to DONE.
    - Shift op with shamt==0: RESULT=A; go to DONE.
    - Shift op with shamt!=0: working register=A, counter=shamt; go to SHIFT.
  - SHIFT: IN_READY=0, OUT_VALID=0. Each cycle shift the working register 1 bit in the captured direction (zero fill) and decrement the counter. When the counter reaches 1 and that final shift is applied, go to DONE.
  - DONE: OUT_VALID=1, RESULT/ZERO stable, IN_READY=0. On OUT_READY=1, go to IDLE.
- Latency (accept edge to OUT_VALID high): non-shift ops and shamt=0 take 1 cycle; shamt=N takes N+1 cycles.
- Handshake rules:
  - Inputs are sampled only on the IN_VALID & IN_READY edge; input changes at any other time are ignored.
  - RESULT holds stable while OUT_VALID=1 and OUT_READY=0 (backpressure of any length).
  - No back-to-back overlap: the next request is accepted at the earliest one cycle after the DONE handshake, i.e. in the next IDLE cycle.
- Boundary conditions:
  - shamt=31: SLL of 1 yields 0x8000_0000 after 32 cycles total.
  - Bits of B above SHAMT_W are ignored for shifts.
  - SLT compares A and B as signed values: 0x8000_0000 < 0x0000_0001.
  - Reset asserted in SHIFT or DONE aborts the operation immediately. After deassertion, outputs are at reset values and no stale OUT_VALID appears.
- ZERO is registered together with RESULT.

Optional Feature:
- Macro: ALU_ITER_BARREL_EN.
- Defined: SLL/SRL are computed with a single-cycle barrel shifter in IDLE and go directly to DONE. Latency is 1 for all ops; the SHIFT state and counter are not instantiated.
- Undefined: iterative shifting as specified above.
- The handshake and encoding are identical in both builds.

Test Plan:
- Reset, then ADD A=0x0000_0005 B=0x0000_0003 with OUT_READY=1 -> OUT_VALID high 1 cycle after accept, RESULT=0x0000_0008, ZERO=0, IN_READY back to 1 next cycle.
- SUB A=0x0000_0007 B=0x0000_0007 -> RESULT=0, ZERO=1. SLT A=0x8000_0000 B=0x0000_0001 -> RESULT=0x0000_0001.
- SLL A=0x0000_0001 B=0x0000_001F -> OUT_VALID after 32 cycles (1 with ALU_ITER_BARREL_EN), RESULT=0x8000_0000. SRL A=0xF000_0000 B=0x0000_0024 (shamt=4) -> 5 cycles, RESULT=0x0F00_0000.
- Shift with shamt=0 (SRL A=0x1234_5678 B=0x0000_0020) -> 1 cycle, RESULT=0x1234_5678.
- Backpressure: XOR A=0xFFFF_0000 B=0x0F0F_0F0F with OUT_READY=0 for 10 cycles -> RESULT=0xF0F0_0F0F held stable, IN_READY=0 throughout, with IN_VALID toggled and A/B changed meanwhile; no new accept until after the OUT_READY handshake.
- Drop RST_N mid-SHIFT (SLL shamt=20, at cycle 5) -> OUT_VALID=0, RESULT=0, IN_READY=1 immediately. After release, an ADD 1+1 returns 0x0000_0002 normally.

Source files
------------

// File: rtl/alu_iter_exec.sv
// Purpose: sequential execute unit for the 3-bit ALU_Control code (ADD/SUB/AND/OR/XOR/SLT/SLL/SRL).
// Latency: 1 cycle for logic/arith and shamt=0; shamt=N takes N+1 cycles (1 for all ops with ALU_ITER_BARREL_EN).
// Backpressure: one op in flight; result held in DONE until OUT_READY, IN_READY only in IDLE.
module alu_iter_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       ALU_Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

`ifdef ALU_ITER_BARREL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               is_shift;

`ifndef ALU_ITER_BARREL_EN
    // Remaining shift steps and direction (1 = right) of the op in flight.
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
`endif

    assign shamt    = B[SHAMT_W-1:0];
    assign is_shift = (ALU_Control == OP_SLL) || (ALU_Control == OP_SRL);

    // Single-cycle result for every op except iterative shifts.
    always_comb begin
        alu_res = '0;
        case (ALU_Control)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL:  alu_res = A << shamt;
            OP_SRL:  alu_res = A >> shamt;
            default: alu_res = '0;
        endcase
    end

    // Next-state logic: capture on accept, step the shifter, release on OUT_READY.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
`ifndef ALU_ITER_BARREL_EN
        cnt_d    = cnt_q;
        dir_d    = dir_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
`ifdef ALU_ITER_BARREL_EN
                    result_d = alu_res;
                    state_d  = S_DONE;
`else
                    if (is_shift && (shamt != '0)) begin
                        // Working value lives in the result register while shifting.
                        result_d = A;
                        cnt_d    = shamt;
                        dir_d    = (ALU_Control == OP_SRL);
                        state_d  = S_SHIFT;
                    end else begin
                        // shamt==0 shifts fall out of alu_res as A unchanged.
                        result_d = alu_res;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
`ifndef ALU_ITER_BARREL_EN
            S_SHIFT: begin
                result_d = dir_q ? (result_q >> 1) : (result_q << 1);
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
`ifndef ALU_ITER_BARREL_EN
            cnt_q    <= '0;
            dir_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifndef ALU_ITER_BARREL_EN
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
`endif
        end
    end

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = (state_q == S_DONE);
    assign RESULT    = result_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Purpose: self-checking bench for alu_iter_exec against a behavioural op/latency model.
// Latency: measured in rising edges from the accept edge until OUT_VALID is seen.
// Backpressure: holds OUT_READY low for a chosen number of cycles while perturbing inputs.
module tb_alu_iter_exec;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [2:0]  ALU_Control;
    logic [31:0] A;
    logic [31:0] B;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic        ZERO;

    int nvec = 0;
    int nerr = 0;

    alu_iter_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .ALU_Control(ALU_Control),
        .A          (A),
        .B          (B),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .RESULT     (RESULT),
        .ZERO       (ZERO)
    );

    always #5 CLK = ~CLK;

    // Reference: what the op should produce, straight from the encoding table.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLL:  return a << (b % 32);
            default: return a >> (b % 32);
        endcase
    endfunction

    // Reference: edges from accept to OUT_VALID.
    function automatic int model_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef ALU_ITER_BARREL_EN
        return 1;
`else
        if ((op == OP_SLL || op == OP_SRL) && (b % 32) != 0)
            return int'(b % 32) + 1;
        return 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE (called just after a falling edge), check result, hold, then drain.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        int          el;
        int          lat;
        logic        got;
        er = model(op, a, b);
        el = model_lat(op, b);
        chk("in_ready_idle", {31'd0, IN_READY}, 32'd1);
        ALU_Control = op;
        A           = a;
        B           = b;
        IN_VALID    = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID    = 1'b0;
        A           = $urandom;
        B           = $urandom;
        ALU_Control = 3'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge CLK);
            lat++;
            got = OUT_VALID;
        end
        chk("out_valid_seen", {31'd0, got}, 32'd1);
        chk("latency", 32'(lat), 32'(el));
        chk("result", RESULT, er);
        chk("zero", {31'd0, ZERO}, {31'd0, (er == 32'd0)});
        chk("in_ready_busy", {31'd0, IN_READY}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            IN_VALID    = 1'($urandom);
            A           = $urandom;
            B           = $urandom;
            ALU_Control = 3'($urandom);
            @(negedge CLK);
            chk("hold_result", RESULT, er);
            chk("hold_out_valid", {31'd0, OUT_VALID}, 32'd1);
            chk("hold_in_ready", {31'd0, IN_READY}, 32'd0);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("drain_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("drain_in_ready", {31'd0, IN_READY}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N       = 1'b0;
        IN_VALID    = 1'b0;
        OUT_READY   = 1'b0;
        ALU_Control = 3'd0;
        A           = 32'd0;
        B           = 32'd0;
        repeat (3) @(negedge CLK);

        chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_result", RESULT, 32'd0);
        chk("rst_zero", {31'd0, ZERO}, 32'd1);
        RST_N = 1'b1;
        @(negedge CLK);

        run_op(OP_ADD, 32'h0000_0005, 32'h0000_0003, 0);
        run_op(OP_SUB, 32'h0000_0007, 32'h0000_0007, 0);
        run_op(OP_SLT, 32'h8000_0000, 32'h0000_0001, 0);
        run_op(OP_SLT, 32'h0000_0001, 32'h8000_0000, 0);
        run_op(OP_SLL, 32'h0000_0001, 32'h0000_001F, 0);
        run_op(OP_SRL, 32'hF000_0000, 32'h0000_0024, 0);
        run_op(OP_SRL, 32'h1234_5678, 32'h0000_0020, 0);
        run_op(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 1);
        run_op(OP_OR,  32'hFF00_0000, 32'h0000_00FF, 2);
        run_op(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 10);
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0);

        // Reset in the middle of a long shift must abort with clean outputs.
        ALU_Control = OP_SLL;
        A           = 32'h0000_0001;
        B           = 32'd20;
        IN_VALID    = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("abort_result", RESULT, 32'd0);
        chk("abort_in_ready", {31'd0, IN_READY}, 32'd1);
        chk("abort_zero", {31'd0, ZERO}, 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_abort_out_valid", {31'd0, OUT_VALID}, 32'd0);
        run_op(OP_ADD, 32'h0000_0001, 32'h0000_0001, 0);

        for (int n = 0; n < 24; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            if (n % 4 == 0) b = a;
            run_op(op, a, b, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
